// File: rtl/demux_pkg.sv
// Shared defaults, channel-count limits and slot state type for the 1-to-N stream demux.
package demux_pkg;

    localparam int DEMUX_DATA_W_DEF = 8;
    localparam int DEMUX_N_CH_DEF   = 4;
    localparam int DEMUX_N_CH_MIN   = 2;
    localparam int DEMUX_N_CH_MAX   = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_ch_slot.sv
// One output channel of the demux: a single registered entry with valid/ready handshake.
module demux_ch_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_e state;
    slot_state_e state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load while draining keeps the slot FULL so the new word follows with no bubble.
    always_comb begin
        state_next = state;
        unique case (state)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (out_ready && !load) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    // Data is only written on load, so an emptied slot still shows its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= data_in;
        end
    end

    assign out_valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_1ton_stream.sv
// 1-to-N stream demultiplexer: routes each accepted word to the one-entry slot picked by in_sel.
module demux_1ton_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF,
    parameter int N_CH   = DEMUX_N_CH_DEF,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic                   err_sel
);

    logic [N_CH-1:0] sel_hit;
    logic [N_CH-1:0] ch_load;
    logic            sel_in_range;
    logic            sel_ready;
    logic            accept;

    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < N_CH; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
        end
    end

    // Out-of-range selects are always accepted so they can be dropped and flagged.
    assign sel_in_range = |sel_hit;
    assign sel_ready    = |(sel_hit & (~out_valid | out_ready));
    assign in_ready     = rst_n && (!sel_in_range || sel_ready);
    assign accept       = in_valid && in_ready;
    assign ch_load      = {N_CH{accept}} & sel_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else begin
            err_sel <= accept && !sel_in_range;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_ch_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ch_load[k]),
            .data_in  (in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Scoreboard bench for demux_1ton_stream: per-channel expected-word queues plus a small N_CH=3 instance.
module tb_demux_1ton_stream;

    localparam int DATA_W = 8;
    localparam int N_CH   = 4;
    localparam int SEL_W  = 2;
    localparam int N_CH3  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic                   err_sel;

    logic [DATA_W-1:0]       d3_in_data;
    logic [1:0]              d3_in_sel;
    logic                    d3_in_valid;
    logic                    d3_in_ready;
    logic [N_CH3*DATA_W-1:0] d3_out_data;
    logic [N_CH3-1:0]        d3_out_valid;
    logic [N_CH3-1:0]        d3_out_ready;
    logic                    d3_err_sel;

    demux_1ton_stream #(
        .DATA_W(DATA_W),
        .N_CH  (N_CH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_sel  (err_sel)
    );

    demux_1ton_stream #(
        .DATA_W(DATA_W),
        .N_CH  (N_CH3)
    ) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (d3_in_data),
        .in_sel   (d3_in_sel),
        .in_valid (d3_in_valid),
        .in_ready (d3_in_ready),
        .out_data (d3_out_data),
        .out_valid(d3_out_valid),
        .out_ready(d3_out_ready),
        .err_sel  (d3_err_sel)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] ch_q [N_CH][$];
    logic [DATA_W-1:0] last_word [N_CH];
    bit                err_q [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Each channel is modelled as a queue of words still owed to its consumer.
    task automatic applyStimulus(input logic v, input logic [SEL_W-1:0] s,
                                 input logic [DATA_W-1:0] d, input logic [N_CH-1:0] r);
        bit exp_ready;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        #1;
        if (int'(s) >= N_CH) exp_ready = 1'b1;
        else                 exp_ready = (ch_q[s].size() == 0);
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        if (v && exp_ready) begin
            if (int'(s) < N_CH) ch_q[s].push_back(d);
            err_q.push_back(int'(s) >= N_CH);
        end else begin
            err_q.push_back(1'b0);
        end
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 2'd1;
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data", out_data, 32'd0);
        checkOutput("rst err_sel", 32'(err_sel), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst d3_out_valid", 32'(d3_out_valid), 32'd0);
        for (int k = 0; k < N_CH; k++) begin
            ch_q[k].delete();
            last_word[k] = '0;
        end
        err_q.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic step3(input logic v, input logic [1:0] s, input logic [DATA_W-1:0] d,
                         input logic [N_CH3-1:0] r);
        @(posedge clk);
        #1;
        d3_in_valid  = v;
        d3_in_sel    = s;
        d3_in_data   = d;
        d3_out_ready = r;
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares every channel and err_sel against the scoreboard each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < N_CH; k++) begin
                    checkOutput($sformatf("out_valid[%0d]", k), 32'(out_valid[k]),
                                32'(ch_q[k].size() > 0));
                    if (ch_q[k].size() > 0) begin
                        checkOutput($sformatf("out_data[%0d]", k),
                                    32'(out_data[k*DATA_W +: DATA_W]), 32'(ch_q[k][0]));
                        if (out_ready[k]) last_word[k] = ch_q[k].pop_front();
                    end else begin
                        checkOutput($sformatf("idle out_data[%0d]", k),
                                    32'(out_data[k*DATA_W +: DATA_W]), 32'(last_word[k]));
                    end
                end
                if (err_q.size() > 0) begin
                    checkOutput("err_sel", 32'(err_sel), 32'(err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < N_CH; k++) last_word[k] = '0;
        in_valid     = 1'b1;
        in_sel       = 2'd1;
        in_data      = 8'hC3;
        out_ready    = '1;
        d3_in_valid  = 1'b1;
        d3_in_sel    = 2'd0;
        d3_in_data   = 8'h3C;
        d3_out_ready = '0;
        #3;
        checkOutput("init out_valid", 32'(out_valid), 32'd0);
        checkOutput("init out_data", out_data, 32'd0);
        checkOutput("init in_ready", 32'(in_ready), 32'd0);
        checkOutput("init err_sel", 32'(err_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        d3_in_valid = 1'b0;

        $display("[TB] directed: single word to ch2");
        applyStimulus(1'b1, 2'd2, 8'hA5, 4'hF);
        applyStimulus(1'b0, 2'd2, 8'h00, 4'hF);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

        $display("[TB] directed: ch1 backpressure");
        applyStimulus(1'b1, 2'd1, 8'h11, 4'b1101);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1101);
        applyStimulus(1'b1, 2'd1, 8'h22, 4'b1111);
        applyStimulus(1'b0, 2'd1, 8'h00, 4'b1111);
        applyStimulus(1'b0, 2'd1, 8'h00, 4'b1111);

        $display("[TB] directed: stalled ch0 does not block ch3");
        applyStimulus(1'b1, 2'd0, 8'h44, 4'b1110);
        applyStimulus(1'b1, 2'd3, 8'h33, 4'b1110);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1110);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'b1111);

        $display("[TB] directed: ch2 drain and load together");
        applyStimulus(1'b1, 2'd2, 8'h77, 4'b1011);
        applyStimulus(1'b1, 2'd2, 8'h5A, 4'b1111);
        applyStimulus(1'b0, 2'd2, 8'h00, 4'b1011);
        applyStimulus(1'b0, 2'd2, 8'h00, 4'b1111);

        $display("[TB] directed: reset with ch1 full");
        applyStimulus(1'b1, 2'd1, 8'h99, 4'b0000);
        resetPulse();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if (i == 200) resetPulse();
            applyStimulus(($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 3)),
                          DATA_W'($urandom), N_CH'($urandom_range(0, 15)));
        end
        applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);
        applyStimulus(1'b0, 2'd0, 8'h00, 4'hF);

        $display("[TB] directed: out-of-range select on N_CH=3 instance");
        step3(1'b1, 2'd0, 8'h12, 3'b000);
        checkOutput("d3 in_ready empty", 32'(d3_in_ready), 32'd1);
        step3(1'b0, 2'd0, 8'h00, 3'b000);
        checkOutput("d3 out_valid ch0", 32'(d3_out_valid), 32'b001);
        checkOutput("d3 out_data ch0", 32'(d3_out_data), 32'h00_00_12);
        step3(1'b1, 2'd0, 8'h34, 3'b000);
        checkOutput("d3 in_ready stalled", 32'(d3_in_ready), 32'd0);
        step3(1'b1, 2'd3, 8'hFF, 3'b000);
        checkOutput("d3 in_ready bad sel", 32'(d3_in_ready), 32'd1);
        checkOutput("d3 err_sel before", 32'(d3_err_sel), 32'd0);
        step3(1'b0, 2'd3, 8'h00, 3'b000);
        checkOutput("d3 err_sel pulse", 32'(d3_err_sel), 32'd1);
        checkOutput("d3 out_valid kept", 32'(d3_out_valid), 32'b001);
        checkOutput("d3 out_data kept", 32'(d3_out_data), 32'h00_00_12);
        step3(1'b0, 2'd0, 8'h00, 3'b000);
        checkOutput("d3 err_sel cleared", 32'(d3_err_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
